// File: rtl/circle_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : circle_draw_ctrl
// Description : Control FSM in front of the circle datapath. It can first
//               clear the screen (a raster sweep over 160x120) and then draws
//               a midpoint circle as eight symmetric plots per iteration.
//               It drives the datapath init/load/flag/select strobes and the
//               VGA adapter plot/colour, with a start/done handshake to the
//               top level.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   COLOUR_W      width of colour_in / colour_out
//   CLEAR_COLOUR  colour written during the screen clear
// Ports
//   clk                  in   system clock, all state on rising edge
//   resetn               in   asynchronous active-low reset
//   start                in   level request, sampled in IDLE
//   colour_in            in   circle colour, latched when leaving IDLE
//   xdone/ydone          in   datapath raster counters at 159 / 119
//   cdone                in   datapath circle loop continue (y <= x)
//   initx/inity/initc    out  datapath counter init selects
//   loadx/loady/loadc    out  datapath register enables
//   flagc                out  1 = circle mode, 0 = raster mode
//   selx/sely            out  one-hot pixel coordinate mux selects
//   plot                 out  VGA write enable
//   colour_out           out  VGA pixel colour
//   done                 out  drawing complete
// Configuration macro
//   CIRC_CLEAR_EN  when defined, the clear phase (CLR_INIT/CLR_ROW/CLR_NEXTY)
//                  is built in; otherwise IDLE goes straight to CIRC_INIT and
//                  the screen contents are preserved.
// ============================================================================
module circle_draw_ctrl #(
  parameter int                  COLOUR_W     = 3,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                xdone,
  input  logic                ydone,
  input  logic                cdone,
  output logic                initx,
  output logic                inity,
  output logic                initc,
  output logic                loadx,
  output logic                loady,
  output logic                loadc,
  output logic                flagc,
  output logic [4:0]          selx,
  output logic [4:0]          sely,
  output logic                plot,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
`ifdef CIRC_CLEAR_EN
    S_CLR_INIT  = 4'd1,
    S_CLR_ROW   = 4'd2,
    S_CLR_NEXTY = 4'd3,
`endif
    S_CIRC_INIT = 4'd4,
    S_CIRC_CHK  = 4'd5,
    S_OCT0      = 4'd6,
    S_OCT1      = 4'd7,
    S_OCT2      = 4'd8,
    S_OCT3      = 4'd9,
    S_OCT4      = 4'd10,
    S_OCT5      = 4'd11,
    S_OCT6      = 4'd12,
    S_OCT7      = 4'd13,
    S_CIRC_STEP = 4'd14,
    S_DONE      = 4'd15
  } state_t;

  // All Moore outputs travel together; field order matters for c_reset_out.
  typedef struct packed {
    logic                initx;
    logic                inity;
    logic                initc;
    logic                loadx;
    logic                loady;
    logic                loadc;
    logic                flagc;
    logic [4:0]          selx;
    logic [4:0]          sely;
    logic                plot;
    logic [COLOUR_W-1:0] colour;
    logic                done;
  } ctrl_t;

  // Raster select, no strobes, clear colour: the idle/reset output set.
  localparam ctrl_t c_reset_out = {7'b0000000, 5'b10000, 5'b10000, 1'b0, CLEAR_COLOUR, 1'b0};

  // Coordinate select encodings: X sources (cx+x, cx+y, cx-x, cx-y, raster x),
  // Y sources (cy+y, cy+x, cy-y, cy-x, raster y).
  localparam logic [4:0] c_sel_p0  = 5'b00001;
  localparam logic [4:0] c_sel_p1  = 5'b00010;
  localparam logic [4:0] c_sel_m0  = 5'b00100;
  localparam logic [4:0] c_sel_m1  = 5'b01000;

`ifdef CIRC_CLEAR_EN
  localparam state_t c_run_entry = S_CLR_INIT;
`else
  localparam state_t c_run_entry = S_CIRC_INIT;
`endif

  state_t               r_state;
  state_t               w_next;
  ctrl_t                r_out;
  ctrl_t                w_out;
  logic [COLOUR_W-1:0]  r_colour;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = c_run_entry;
`ifdef CIRC_CLEAR_EN
      S_CLR_INIT:  w_next = S_CLR_ROW;
      S_CLR_ROW:   if (xdone) w_next = ydone ? S_CIRC_INIT : S_CLR_NEXTY;
      S_CLR_NEXTY: w_next = S_CLR_ROW;
`endif
      S_CIRC_INIT: w_next = S_CIRC_CHK;
      S_CIRC_CHK:  w_next = cdone ? S_OCT0 : S_DONE;
      S_OCT0:      w_next = S_OCT1;
      S_OCT1:      w_next = S_OCT2;
      S_OCT2:      w_next = S_OCT3;
      S_OCT3:      w_next = S_OCT4;
      S_OCT4:      w_next = S_OCT5;
      S_OCT5:      w_next = S_OCT6;
      S_OCT6:      w_next = S_OCT7;
      S_OCT7:      w_next = S_CIRC_STEP;
      S_CIRC_STEP: w_next = S_CIRC_CHK;
      S_DONE:      if (!start) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode of the state being entered, so the registered outputs line
  // up with the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    w_out = c_reset_out;
    case (w_next)
`ifdef CIRC_CLEAR_EN
      S_CLR_INIT: begin
        w_out.initx = 1'b1;
        w_out.loadx = 1'b1;
        w_out.inity = 1'b1;
        w_out.loady = 1'b1;
      end
      S_CLR_ROW: begin
        w_out.plot  = 1'b1;
        w_out.loadx = 1'b1;
      end
      S_CLR_NEXTY: begin
        w_out.initx = 1'b1;
        w_out.loadx = 1'b1;
        w_out.loady = 1'b1;
      end
`endif
      S_CIRC_INIT: begin
        w_out.flagc = 1'b1;
        w_out.initx = 1'b1;
        w_out.inity = 1'b1;
        w_out.initc = 1'b1;
        w_out.loadx = 1'b1;
        w_out.loady = 1'b1;
        w_out.loadc = 1'b1;
      end
      S_CIRC_CHK: w_out.flagc = 1'b1;
      S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6, S_OCT7: begin
        w_out.flagc  = 1'b1;
        w_out.plot   = 1'b1;
        // Colour is already latched: OCT states are never entered from IDLE.
        w_out.colour = r_colour;
        case (w_next)
          S_OCT0:  begin w_out.selx = c_sel_p0; w_out.sely = c_sel_p0; end
          S_OCT1:  begin w_out.selx = c_sel_p1; w_out.sely = c_sel_p1; end
          S_OCT2:  begin w_out.selx = c_sel_m0; w_out.sely = c_sel_p0; end
          S_OCT3:  begin w_out.selx = c_sel_m1; w_out.sely = c_sel_p1; end
          S_OCT4:  begin w_out.selx = c_sel_m0; w_out.sely = c_sel_m0; end
          S_OCT5:  begin w_out.selx = c_sel_m1; w_out.sely = c_sel_m1; end
          S_OCT6:  begin w_out.selx = c_sel_p0; w_out.sely = c_sel_m0; end
          default: begin w_out.selx = c_sel_p1; w_out.sely = c_sel_m1; end
        endcase
      end
      S_CIRC_STEP: begin
        w_out.flagc = 1'b1;
        w_out.loadx = 1'b1;
        w_out.loady = 1'b1;
        w_out.loadc = 1'b1;
      end
      S_DONE:  w_out.done = 1'b1;
      default: w_out = c_reset_out;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, outputs and colour latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_out    <= c_reset_out;
      r_colour <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= w_out;
      if (r_state == S_IDLE && start) r_colour <= colour_in;
    end
  end

  assign initx      = r_out.initx;
  assign inity      = r_out.inity;
  assign initc      = r_out.initc;
  assign loady      = r_out.loady;
  assign loadc      = r_out.loadc;
  assign flagc      = r_out.flagc;
  assign selx       = r_out.selx;
  assign sely       = r_out.sely;
  assign plot       = r_out.plot;
  assign colour_out = r_out.colour;
  assign done       = r_out.done;

`ifdef CIRC_CLEAR_EN
  // xdone is only known in the cycle the last column is plotted, so the row
  // increment is masked there; x is re-initialised by CLR_NEXTY instead of
  // being pushed past 159.
  assign loadx = r_out.loadx & ~((r_state == S_CLR_ROW) & xdone);
`else
  logic w_unused_raster_flags;
  assign w_unused_raster_flags = &{1'b0, xdone, ydone};
  assign loadx = r_out.loadx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_circle_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_circle_draw_ctrl
// Description : Directed bench for circle_draw_ctrl with a behavioural circle
//               datapath (R=40, centre (80,40)) and a pixel monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circle_draw_ctrl;

  localparam int c_r  = 40;
  localparam int c_cx = 80;
  localparam int c_cy = 40;

`ifdef CIRC_CLEAR_EN
  localparam logic [6:0] c_first_strobes = 7'b1101100;
  localparam int         c_init_dly      = 19320;
  localparam int         c_clear_plots   = 19200;
  localparam int         c_abort_cyc     = 5000;
`else
  localparam logic [6:0] c_first_strobes = 7'b1111111;
  localparam int         c_init_dly      = 0;
  localparam int         c_clear_plots   = 0;
  localparam int         c_abort_cyc     = 95;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [2:0] colour_in = 3'b000;
  logic       xdone, ydone, cdone;
  logic       initx, inity, initc, loadx, loady, loadc, flagc;
  logic [4:0] selx, sely;
  logic       plot, done;
  logic [2:0] colour_out;
  logic [6:0] strobes;

  int total = 0;
  int bad   = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  circle_draw_ctrl #(.COLOUR_W(3), .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .start(start), .colour_in(colour_in),
    .xdone(xdone), .ydone(ydone), .cdone(cdone),
    .initx(initx), .inity(inity), .initc(initc),
    .loadx(loadx), .loady(loady), .loadc(loadc), .flagc(flagc),
    .selx(selx), .sely(sely), .plot(plot), .colour_out(colour_out), .done(done)
  );

  assign strobes = {initx, inity, initc, loadx, loady, loadc, flagc};

  // Behavioural datapath
  int mx = 0;
  int my = 0;
  int mc = 0;
  always @(posedge clk) begin
    if (!flagc) begin
      if (loadx) mx <= initx ? 0 : mx + 1;
      if (loady) my <= inity ? 0 : my + 1;
    end else if (initx || inity || initc) begin
      if (initx && loadx) mx <= c_r;
      if (inity && loady) my <= 0;
      if (initc && loadc) mc <= 1 - c_r;
    end else if (loadx && loady && loadc) begin
      my <= my + 1;
      if (mc <= 0) mc <= mc + 2 * (my + 1) + 1;
      else begin
        mx <= mx - 1;
        mc <= mc + 2 * ((my + 1) - (mx - 1)) + 1;
      end
    end
  end
  assign xdone = (mx == 159);
  assign ydone = (my == 119);
  assign cdone = (my <= mx);

  int xp, yp;
  always_comb begin
    case (selx)
      5'b00001: xp = c_cx + mx;
      5'b00010: xp = c_cx + my;
      5'b00100: xp = c_cx - mx;
      5'b01000: xp = c_cx - my;
      5'b10000: xp = mx;
      default:  xp = -1;
    endcase
    case (sely)
      5'b00001: yp = c_cy + my;
      5'b00010: yp = c_cy + mx;
      5'b00100: yp = c_cy - my;
      5'b01000: yp = c_cy - mx;
      5'b10000: yp = my;
      default:  yp = -1;
    endcase
  end

  // Pixel / event monitor (counters are monotonic; tasks take deltas)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  seen [0:19199];
  int  circ_x [0:1023];
  int  circ_y [0:1023];
  int  n_plot = 0, n_clr = 0, n_circ = 0, n_other = 0;
  int  n_uniq = 0, n_dup = 0, n_oob = 0;
  int  n_overlap = 0, n_xdone_load = 0, n_steps = 0;
  int  t_init = 0, t_done = 0;
  int  clr_pass = -1, first_x = -1, first_y = -1;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        n_plot <= n_plot + 1;
        if (loady || loadc || (loadx && flagc)) n_overlap <= n_overlap + 1;
        if (loadx && xdone) n_xdone_load <= n_xdone_load + 1;
        if (colour_out == 3'b000) begin
          n_clr <= n_clr + 1;
          if (clr_pass != pass) begin
            clr_pass <= pass;
            first_x  <= xp;
            first_y  <= yp;
          end
          if (xp >= 0 && xp < 160 && yp >= 0 && yp < 120) begin
            if (seen[yp*160+xp] == pass) n_dup <= n_dup + 1;
            else begin
              seen[yp*160+xp] <= pass;
              n_uniq <= n_uniq + 1;
            end
          end else n_oob <= n_oob + 1;
        end else if (colour_out == 3'b100) begin
          if (n_circ < 1024) begin
            circ_x[n_circ] <= xp;
            circ_y[n_circ] <= yp;
          end
          n_circ <= n_circ + 1;
        end else n_other <= n_other + 1;
      end
      if (flagc && initx && loadx) t_init <= cyc;
      if (flagc && loadx && loady && loadc && !initx) n_steps <= n_steps + 1;
      if (done && !done_q) t_done <= cyc;
    end
    done_q <= done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    resetn = 1'b0; start = 1'b1; colour_in = 3'b100;
    repeat (3) tick();
    total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot: got %b want 0", plot); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (strobes !== 7'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0000000", strobes); end
    total++; if (selx !== 5'b10000) begin bad++; $display("FAIL reset_selx: got %b want 10000", selx); end
    total++; if (sely !== 5'b10000) begin bad++; $display("FAIL reset_sely: got %b want 10000", sely); end
    total++; if (colour_out !== 3'b000) begin bad++; $display("FAIL reset_colour: got %b want 000", colour_out); end
    resetn = 1'b1;
    tick();
    total++; if (strobes !== c_first_strobes) begin bad++; $display("FAIL reset_leave_idle: strobes %b want %b", strobes, c_first_strobes); end
    resetn = 1'b0;
    tick();
    start = 1'b0; resetn = 1'b1;
    tick(); tick();
    total++; if (strobes !== 7'b0) begin bad++; $display("FAIL idle_hold_strobes: got %b want 0000000", strobes); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_hold_done: got %b want 0", done); end
  endtask

  // Clear (when built) followed by an R=40 circle
  task automatic test_draw;
    int n, b_circ, b_clr, b_oth, b_steps, b_uniq, b_dup, b_oob, t0;
    int ex [8] = '{120, 80, 40, 80, 40, 80, 120, 80};
    int ey [8] = '{ 40, 80, 40, 80, 40,  0,  40,  0};
    pass++;
    b_circ = n_circ; b_clr = n_clr; b_oth = n_other; b_steps = n_steps;
    b_uniq = n_uniq; b_dup = n_dup; b_oob = n_oob;
    colour_in = 3'b100; start = 1'b1;
    tick();
    t0 = cyc;
    total++; if (strobes !== c_first_strobes) begin bad++; $display("FAIL draw_first_state: strobes %b want %b", strobes, c_first_strobes); end
    colour_in = 3'b010;   // must be ignored for the rest of this run
    n = 0;
    while (done !== 1'b1 && n < 30000) begin tick(); n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL draw_done_timeout: done=%b after %0d cycles want 1", done, n); end
    tick();
    total++; if (t_init - t0 !== c_init_dly) begin bad++; $display("FAIL draw_circ_init_cycle: got %0d want %0d", t_init - t0, c_init_dly); end
    total++; if (t_done - t_init !== 292) begin bad++; $display("FAIL draw_done_latency: got %0d want 292", t_done - t_init); end
    total++; if (n_circ - b_circ !== 232) begin bad++; $display("FAIL draw_circle_plots: got %0d want 232", n_circ - b_circ); end
    total++; if (n_steps - b_steps !== 29) begin bad++; $display("FAIL draw_iterations: got %0d want 29", n_steps - b_steps); end
    total++; if (n_clr - b_clr !== c_clear_plots) begin bad++; $display("FAIL draw_clear_plots: got %0d want %0d", n_clr - b_clr, c_clear_plots); end
    total++; if (n_other - b_oth !== 0) begin bad++; $display("FAIL draw_stray_colour: got %0d want 0", n_other - b_oth); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (circ_x[b_circ+i] !== ex[i] || circ_y[b_circ+i] !== ey[i]) begin
        bad++;
        $display("FAIL draw_pixel%0d: got (%0d,%0d) want (%0d,%0d)", i, circ_x[b_circ+i], circ_y[b_circ+i], ex[i], ey[i]);
      end
    end
`ifdef CIRC_CLEAR_EN
    total++; if (n_uniq - b_uniq !== 19200) begin bad++; $display("FAIL clear_coverage: got %0d want 19200", n_uniq - b_uniq); end
    total++; if (n_dup - b_dup !== 0) begin bad++; $display("FAIL clear_duplicates: got %0d want 0", n_dup - b_dup); end
    total++; if (n_oob - b_oob !== 0) begin bad++; $display("FAIL clear_out_of_range: got %0d want 0", n_oob - b_oob); end
    total++; if (first_x !== 0 || first_y !== 0) begin bad++; $display("FAIL clear_first_pixel: got (%0d,%0d) want (0,0)", first_x, first_y); end
`endif
  endtask

  task automatic test_handshake;
    int lows, b_plot;
    lows = 0; b_plot = n_plot;
    repeat (20) begin
      tick();
      if (done !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL hs_done_held: %0d low cycles want 0", lows); end
    total++; if (n_plot - b_plot !== 0) begin bad++; $display("FAIL hs_no_plots: got %0d want 0", n_plot - b_plot); end
    start = 1'b0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hs_done_drop: got %b want 0", done); end
    tick();
    total++; if (strobes !== 7'b0 || plot !== 1'b0) begin bad++; $display("FAIL hs_idle: strobes %b plot %b want 0", strobes, plot); end
  endtask

  task automatic test_abort;
    int n, b_circ, b_uniq;
    pass++;
    colour_in = 3'b100; start = 1'b1;
    tick();
    repeat (c_abort_cyc) tick();
    total++; if (plot !== 1'b1) begin bad++; $display("FAIL abort_precond_plot: got %b want 1", plot); end
    resetn = 1'b0;
    #1;
    total++; if (plot !== 1'b0 || strobes !== 7'b0) begin bad++; $display("FAIL abort_outputs: plot %b strobes %b want 0", plot, strobes); end
    total++; if (selx !== 5'b10000 || sely !== 5'b10000) begin bad++; $display("FAIL abort_sel: got %b/%b want 10000", selx, sely); end
    total++; if (done !== 1'b0 || colour_out !== 3'b000) begin bad++; $display("FAIL abort_done_colour: done %b colour %b want 0/000", done, colour_out); end
    tick();
    pass++;
    b_circ = n_circ; b_uniq = n_uniq;
    resetn = 1'b1;
    tick();
    start = 1'b0;   // dropped mid-run: run still completes
    n = 0;
    while (done !== 1'b1 && n < 30000) begin tick(); n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done_timeout: done=%b after %0d cycles want 1", done, n); end
    tick();
    total++; if (done !== 1'b0 || strobes !== 7'b0) begin bad++; $display("FAIL restart_back_to_idle: done %b strobes %b want 0", done, strobes); end
    total++; if (n_circ - b_circ !== 232) begin bad++; $display("FAIL restart_circle_plots: got %0d want 232", n_circ - b_circ); end
    total++; if (circ_x[b_circ] !== 120 || circ_y[b_circ] !== 40) begin bad++; $display("FAIL restart_first_circle_pixel: got (%0d,%0d) want (120,40)", circ_x[b_circ], circ_y[b_circ]); end
`ifdef CIRC_CLEAR_EN
    total++; if (n_uniq - b_uniq !== 19200) begin bad++; $display("FAIL restart_clear_coverage: got %0d want 19200", n_uniq - b_uniq); end
    total++; if (first_x !== 0 || first_y !== 0) begin bad++; $display("FAIL restart_clear_origin: got (%0d,%0d) want (0,0)", first_x, first_y); end
`endif
  endtask

  task automatic test_invariants;
    tick();
    total++; if (n_overlap !== 0) begin bad++; $display("FAIL plot_load_overlap: got %0d want 0", n_overlap); end
    total++; if (n_xdone_load !== 0) begin bad++; $display("FAIL load_on_xdone: got %0d want 0", n_xdone_load); end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_handshake();
    test_abort();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
